rgb_frame_gen: RTL

Upstream pixel source for the RGB processing stage. Generates a raster-scanned synthetic frame with test patterns. Per pixel it drives: 8-bit R/G/B, a valid strobe, a frame-window pixel enable, an end-of-frame pulse and X/Y coordinates. Used as the stimulus front end on the board and as a reference stream in the UVM environment.

---
 rtl/rgb_frame_gen_if.sv | 24 ++
 rtl/rgb_frame_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_frame_gen_if.sv
// Pixel stream bundle between the synthetic frame generator (master) and its consumer (slave).
interface rgb_frame_gen_if;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic [7:0]  oRed;
   logic [7:0]  oGreen;
   logic [7:0]  oBlue;
   logic        oValid;
   logic        oPixelEn;
   logic        oEof;
   logic [31:0] oX;
   logic [31:0] oY;
   logic [15:0] frame_count;

   modport master (
      input  enable, pattern_sel,
      output oRed, oGreen, oBlue, oValid, oPixelEn, oEof, oX, oY, frame_count
   );

   modport slave (
      output enable, pattern_sel,
      input  oRed, oGreen, oBlue, oValid, oPixelEn, oEof, oX, oY, frame_count
   );
endinterface

// File: rtl/rgb_frame_gen.sv
// Raster-scanned synthetic frame source: ramp, bar and checkerboard test patterns.
// Raster counters run one cycle ahead of the registered pixel outputs.
module rgb_frame_gen #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned HBLANK     = 16,
   parameter int unsigned VBLANK     = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   rgb_frame_gen_if.master pix
);
   localparam int unsigned XW   = $clog2(IMG_WIDTH);
   localparam int unsigned YW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int unsigned BLK  = (HBLANK > VBLANK) ? HBLANK : VBLANK;
   localparam int unsigned BW   = (BLK > 1) ? $clog2(BLK) : 1;
   localparam int unsigned BARW = IMG_WIDTH / 8;
   localparam int unsigned CW   = (BARW > 1) ? $clog2(BARW) : 1;

   localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
   localparam logic [BW-1:0] H_LAST   = BW'(HBLANK - 1);
   localparam logic [BW-1:0] V_LAST   = BW'(VBLANK - 1);
   localparam logic [CW-1:0] BAR_LAST = CW'(BARW - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [CW-1:0] bar_cnt_q, bar_cnt_d;
   logic [2:0]    bar_idx_q, bar_idx_d;
   logic [1:0]    pat_q, pat_d;

   logic [7:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic          valid_q, valid_d, pen_q, pen_d, eof_q, eof_d;
   logic [XW-1:0] ox_q, ox_d;
   logic [YW-1:0] oy_q, oy_d;
   logic [15:0]   fcnt_q, fcnt_d;

   logic [7:0]    x8, y8;
   assign x8 = 8'(x_q);
   assign y8 = 8'(y_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         bcnt_q    <= '0;
         bar_cnt_q <= '0;
         bar_idx_q <= '0;
         pat_q     <= '0;
         red_q     <= '0;
         green_q   <= '0;
         blue_q    <= '0;
         valid_q   <= 1'b0;
         pen_q     <= 1'b0;
         eof_q     <= 1'b0;
         ox_q      <= '0;
         oy_q      <= '0;
         fcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         bcnt_q    <= bcnt_d;
         bar_cnt_q <= bar_cnt_d;
         bar_idx_q <= bar_idx_d;
         pat_q     <= pat_d;
         red_q     <= red_d;
         green_q   <= green_d;
         blue_q    <= blue_d;
         valid_q   <= valid_d;
         pen_q     <= pen_d;
         eof_q     <= eof_d;
         ox_q      <= ox_d;
         oy_q      <= oy_d;
         fcnt_q    <= fcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      bcnt_d    = bcnt_q;
      pat_d     = pat_q;
      bar_cnt_d = '0;
      bar_idx_d = '0;
      unique case (state_q)
         S_IDLE: begin
            if (pix.enable) begin
               state_d = S_ACTIVE;
               x_d     = '0;
               y_d     = '0;
               pat_d   = pix.pattern_sel;
            end
         end
         S_ACTIVE: begin
            // Bar position counts through each line and is cleared outside ACTIVE.
            if (bar_cnt_q == BAR_LAST) begin
               bar_idx_d = bar_idx_q + 3'd1;
            end else begin
               bar_cnt_d = bar_cnt_q + CW'(1);
               bar_idx_d = bar_idx_q;
            end
            if (x_q == X_LAST) begin
               bcnt_d  = '0;
               state_d = (y_q == Y_LAST) ? S_VBLANK : S_HBLANK;
            end else begin
               x_d = x_q + XW'(1);
            end
         end
         S_HBLANK: begin
            if (bcnt_q == H_LAST) begin
               state_d = S_ACTIVE;
               x_d     = '0;
               y_d     = y_q + YW'(1);
            end else begin
               bcnt_d = bcnt_q + BW'(1);
            end
         end
         S_VBLANK: begin
            if (bcnt_q == V_LAST) begin
               if (pix.enable) begin
                  state_d = S_ACTIVE;
                  x_d     = '0;
                  y_d     = '0;
                  pat_d   = pix.pattern_sel;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               bcnt_d = bcnt_q + BW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      valid_d = 1'b0;
      eof_d   = 1'b0;
      pen_d   = (state_q != S_IDLE);
      ox_d    = ox_q;
      oy_d    = oy_q;
      fcnt_d  = eof_q ? fcnt_q + 16'd1 : fcnt_q;
      if (state_q == S_ACTIVE) begin
         valid_d = 1'b1;
         ox_d    = x_q;
         oy_d    = y_q;
         eof_d   = (x_q == X_LAST) && (y_q == Y_LAST);
         unique case (pat_q)
            2'd0: begin
               red_d  = x8;
               blue_d = ~x8;
            end
            2'd1: green_d = y8;
            2'd2: begin
               red_d   = {8{~bar_idx_q[1]}};
               green_d = {8{~bar_idx_q[2]}};
               blue_d  = {8{~bar_idx_q[0]}};
            end
            default: begin
               if (!(x8[3] ^ y8[3])) begin
                  red_d   = '1;
                  green_d = '1;
                  blue_d  = '1;
               end
            end
         endcase
      end
   end

   assign pix.oRed        = red_q;
   assign pix.oGreen      = green_q;
   assign pix.oBlue       = blue_q;
   assign pix.oValid      = valid_q;
   assign pix.oPixelEn    = pen_q;
   assign pix.oEof        = eof_q;
   assign pix.oX          = 32'(ox_q);
   assign pix.oY          = 32'(oy_q);
   assign pix.frame_count = fcnt_q;
endmodule
